commit_n: RTL

COMMIT_N -- requirements
Module: commit_n

---
 rtl/commit_n_pkg.sv | 33 +++
 rtl/commit_retrat.sv | 69 ++++++
 rtl/commit_n.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/commit_n_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : commit_n_pkg
//  Description : Shared types for the in-order commit stage: ROB entry
//                layout, commit FSM states and architectural register count.
//  Revision    : 1.0  initial release
// ============================================================================
package commit_n_pkg;

    localparam int ARCH_REGS      = 32;
    localparam int ARCH_WIDTH     = 5;
    // Entry storage is sized for the widest supported physical specifier;
    // narrower configurations zero-extend on write and truncate on read.
    localparam int PREG_WIDTH_MAX = 8;

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_RECOVER = 1'b1
    } state_e;

    typedef struct packed {
        logic                      valid;
        logic                      finished;
        logic                      exc;
        logic                      redirect;
        logic                      hasdest;
        logic [ARCH_WIDTH-1:0]     arch;
        logic [PREG_WIDTH_MAX-1:0] preg;
        logic [31:0]               target;
    } rob_entry_t;

endpackage
`default_nettype wire

// File: rtl/commit_retrat.sv
`default_nettype none
// ============================================================================
//  Module      : commit_retrat
//  Description : Retirement RAT. Applies up to COMMIT_WIDTH in-order
//                destination updates per cycle and reports the physical
//                register each update displaces.
//  Revision    : 1.0  initial release
// ============================================================================
module commit_retrat
    import commit_n_pkg::*;
#(
    parameter int COMMIT_WIDTH = 2,
    parameter int PREG_WIDTH   = 6
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               en_i,
    input  logic [COMMIT_WIDTH-1:0]            slot_commit_i,
    input  logic [COMMIT_WIDTH*ARCH_WIDTH-1:0] slot_arch_i,
    input  logic [COMMIT_WIDTH*PREG_WIDTH-1:0] slot_preg_i,
    output logic [COMMIT_WIDTH-1:0]            free_valid_o,
    output logic [COMMIT_WIDTH*PREG_WIDTH-1:0] free_preg_o,
    output logic [ARCH_REGS*PREG_WIDTH-1:0]    retrat_o
);

    logic [PREG_WIDTH-1:0]              rat_q [ARCH_REGS];
    logic [PREG_WIDTH-1:0]              rat_d [ARCH_REGS];
    logic [COMMIT_WIDTH-1:0]            free_valid_q, free_valid_d;
    logic [COMMIT_WIDTH*PREG_WIDTH-1:0] free_preg_q,  free_preg_d;

    // Walk slots oldest first against a running copy of the RAT so a later
    // slot writing the same arch register displaces the earlier slot's preg.
    always_comb begin
        rat_d        = rat_q;
        free_valid_d = '0;
        free_preg_d  = '0;
        for (int s = 0; s < COMMIT_WIDTH; s++) begin
            if (slot_commit_i[s] && (slot_arch_i[s*ARCH_WIDTH +: ARCH_WIDTH] != '0)) begin
                free_valid_d[s]                        = 1'b1;
                free_preg_d[s*PREG_WIDTH +: PREG_WIDTH] = rat_d[slot_arch_i[s*ARCH_WIDTH +: ARCH_WIDTH]];
                rat_d[slot_arch_i[s*ARCH_WIDTH +: ARCH_WIDTH]] = slot_preg_i[s*PREG_WIDTH +: PREG_WIDTH];
            end
        end
    end

    // RAT and free-list release are registered; everything holds while stalled.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int a = 0; a < ARCH_REGS; a++) begin
                rat_q[a] <= PREG_WIDTH'(a);
            end
            free_valid_q <= '0;
            free_preg_q  <= '0;
        end else if (en_i) begin
            rat_q        <= rat_d;
            free_valid_q <= free_valid_d;
            free_preg_q  <= free_preg_d;
        end
    end

    for (genvar a = 0; a < ARCH_REGS; a++) begin : g_retrat_flat
        assign retrat_o[a*PREG_WIDTH +: PREG_WIDTH] = rat_q[a];
    end

    assign free_valid_o = free_valid_q;
    assign free_preg_o  = free_preg_q;

endmodule
`default_nettype wire

// File: rtl/commit_n.sv
`default_nettype none
// ============================================================================
//  Module      : commit_n
//  Description : Reorder buffer with N-wide in-order retirement, retirement
//                RAT maintenance and single-cycle flush/redirect recovery.
//                Optional macro COMMIT_PERF_CNT_EN adds saturating retired
//                and flush counters.
//  Revision    : 1.0  initial release
// ============================================================================
module commit_n
    import commit_n_pkg::*;
#(
    parameter int          COMMIT_WIDTH  = 2,
    parameter int          ROB_ADDRWIDTH = 5,
    parameter int          PREG_WIDTH    = 6,
    parameter logic [31:0] EXC_VECTOR    = 32'h0000_0080
) (
    input  logic                               CLK,
    input  logic                               RESET,
    input  logic                               FREEZE,
    input  logic                               alloc_valid_IN,
    input  logic [4:0]                         alloc_arch_IN,
    input  logic [PREG_WIDTH-1:0]              alloc_preg_IN,
    input  logic                               alloc_hasdest_IN,
    output logic                               alloc_ready_OUT,
    output logic [ROB_ADDRWIDTH-1:0]           alloc_idx_OUT,
    input  logic                               fin_valid_IN,
    input  logic [ROB_ADDRWIDTH-1:0]           fin_idx_IN,
    input  logic                               fin_exc_IN,
    input  logic                               fin_redirect_IN,
    input  logic [31:0]                        fin_target_IN,
    output logic [COMMIT_WIDTH-1:0]            free_valid_OUT,
    output logic [COMMIT_WIDTH*PREG_WIDTH-1:0] free_preg_OUT,
    output logic                               flush_OUT,
    output logic                               copy_retrat_OUT,
    output logic                               redirect_valid_OUT,
    output logic [31:0]                        redirect_pc_OUT,
    output logic [ARCH_REGS*PREG_WIDTH-1:0]    retrat_OUT,
`ifdef COMMIT_PERF_CNT_EN
    output logic [31:0]                        perf_retired_OUT,
    output logic [15:0]                        perf_flushes_OUT,
`endif
    output logic [2:0]                         commit_cnt_OUT
);

    localparam int DEPTH = 2**ROB_ADDRWIDTH;
    localparam int CNT_W = ROB_ADDRWIDTH + 1;

    state_e                         state_q;
    rob_entry_t                     rob_q [DEPTH];
    logic [ROB_ADDRWIDTH-1:0]       head_q, tail_q;
    logic [CNT_W-1:0]               count_q;
    logic                           flush_q;
    logic                           redirect_valid_q;
    logic [31:0]                    redirect_pc_q;
    logic [2:0]                     commit_cnt_q;

    logic                           w_active;
    logic                           w_push;
    logic                           w_stop;
    rob_entry_t                     w_ent;
    logic [COMMIT_WIDTH-1:0]        w_slot_commit;
    logic [COMMIT_WIDTH-1:0]        w_slot_hasdest;
    logic [COMMIT_WIDTH*ARCH_WIDTH-1:0] w_slot_arch;
    logic [COMMIT_WIDTH*PREG_WIDTH-1:0] w_slot_preg;
    logic [2:0]                     w_ret_n;
    logic                           w_recover;
    logic [31:0]                    w_recover_pc;

    assign w_active        = (state_q == ST_RUN) && !FREEZE;
    assign alloc_ready_OUT = (count_q < CNT_W'(DEPTH));
    assign alloc_idx_OUT   = tail_q;
    assign w_push          = w_active && alloc_valid_IN && alloc_ready_OUT;

    // Retire the longest finished prefix from head. An exception stops before
    // its entry; a redirect retires its entry and then stops. Either starts recovery.
    always_comb begin
        w_slot_commit  = '0;
        w_slot_hasdest = '0;
        w_slot_arch    = '0;
        w_slot_preg    = '0;
        w_ret_n        = 3'd0;
        w_recover      = 1'b0;
        w_recover_pc   = 32'd0;
        w_ent          = '0;
        w_stop         = !w_active;
        for (int s = 0; s < COMMIT_WIDTH; s++) begin
            w_ent = rob_q[head_q + ROB_ADDRWIDTH'(s)];
            if (!w_stop) begin
                if ((CNT_W'(s) < count_q) && w_ent.valid && w_ent.finished) begin
                    if (w_ent.exc) begin
                        w_recover    = 1'b1;
                        w_recover_pc = EXC_VECTOR;
                        w_stop       = 1'b1;
                    end else begin
                        w_slot_commit[s]                        = 1'b1;
                        w_slot_hasdest[s]                       = w_ent.hasdest;
                        w_slot_arch[s*ARCH_WIDTH +: ARCH_WIDTH] = w_ent.arch;
                        w_slot_preg[s*PREG_WIDTH +: PREG_WIDTH] = w_ent.preg[PREG_WIDTH-1:0];
                        w_ret_n                                 = w_ret_n + 3'd1;
                        if (w_ent.redirect) begin
                            w_recover    = 1'b1;
                            w_recover_pc = w_ent.target;
                            w_stop       = 1'b1;
                        end
                    end
                end else begin
                    w_stop = 1'b1;
                end
            end
        end
    end

    if (PREG_WIDTH < PREG_WIDTH_MAX) begin : g_preg_pad
        logic unused_preg_hi;
        assign unused_preg_hi = ^w_ent.preg[PREG_WIDTH_MAX-1:PREG_WIDTH];
    end

    // Commit FSM with ROB bookkeeping; recovery outputs are registered pulses.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q          <= ST_RUN;
            head_q           <= '0;
            tail_q           <= '0;
            count_q          <= '0;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'd0;
            commit_cnt_q     <= 3'd0;
            for (int i = 0; i < DEPTH; i++) begin
                rob_q[i] <= '0;
            end
        end else if (!FREEZE) begin
            case (state_q)
                ST_RUN: begin
                    flush_q          <= 1'b0;
                    redirect_valid_q <= 1'b0;
                    commit_cnt_q     <= w_ret_n;
                    if (fin_valid_IN && rob_q[fin_idx_IN].valid) begin
                        rob_q[fin_idx_IN].finished <= 1'b1;
                        rob_q[fin_idx_IN].exc      <= fin_exc_IN;
                        rob_q[fin_idx_IN].redirect <= fin_redirect_IN;
                        rob_q[fin_idx_IN].target   <= fin_target_IN;
                    end
                    for (int s = 0; s < COMMIT_WIDTH; s++) begin
                        if (w_slot_commit[s]) begin
                            rob_q[head_q + ROB_ADDRWIDTH'(s)].valid <= 1'b0;
                        end
                    end
                    if (w_push) begin
                        rob_q[tail_q] <= '{valid:    1'b1,
                                           finished: 1'b0,
                                           exc:      1'b0,
                                           redirect: 1'b0,
                                           hasdest:  alloc_hasdest_IN,
                                           arch:     alloc_arch_IN,
                                           preg:     PREG_WIDTH_MAX'(alloc_preg_IN),
                                           target:   32'd0};
                    end
                    head_q  <= head_q + ROB_ADDRWIDTH'(w_ret_n);
                    tail_q  <= tail_q + ROB_ADDRWIDTH'(w_push);
                    count_q <= count_q + CNT_W'(w_push) - CNT_W'(w_ret_n);
                    if (w_recover) begin
                        state_q          <= ST_RECOVER;
                        flush_q          <= 1'b1;
                        redirect_valid_q <= 1'b1;
                        redirect_pc_q    <= w_recover_pc;
                    end
                end
                ST_RECOVER: begin
                    state_q          <= ST_RUN;
                    flush_q          <= 1'b0;
                    redirect_valid_q <= 1'b0;
                    commit_cnt_q     <= 3'd0;
                    head_q           <= '0;
                    tail_q           <= '0;
                    count_q          <= '0;
                    for (int i = 0; i < DEPTH; i++) begin
                        rob_q[i].valid <= 1'b0;
                    end
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    commit_retrat #(
        .COMMIT_WIDTH (COMMIT_WIDTH),
        .PREG_WIDTH   (PREG_WIDTH)
    ) u_retrat (
        .clk_i         (CLK),
        .rst_i         (RESET),
        .en_i          (!FREEZE),
        .slot_commit_i (w_slot_commit & w_slot_hasdest),
        .slot_arch_i   (w_slot_arch),
        .slot_preg_i   (w_slot_preg),
        .free_valid_o  (free_valid_OUT),
        .free_preg_o   (free_preg_OUT),
        .retrat_o      (retrat_OUT)
    );

`ifdef COMMIT_PERF_CNT_EN
    logic [31:0] perf_retired_q;
    logic [15:0] perf_flushes_q;

    // Saturating event counters, held while stalled.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            perf_retired_q <= 32'd0;
            perf_flushes_q <= 16'd0;
        end else if (!FREEZE) begin
            if (w_ret_n != 3'd0) begin
                if (perf_retired_q > (32'hFFFF_FFFF - 32'(w_ret_n))) begin
                    perf_retired_q <= 32'hFFFF_FFFF;
                end else begin
                    perf_retired_q <= perf_retired_q + 32'(w_ret_n);
                end
            end
            if ((state_q == ST_RECOVER) && (perf_flushes_q != 16'hFFFF)) begin
                perf_flushes_q <= perf_flushes_q + 16'd1;
            end
        end
    end

    assign perf_retired_OUT = perf_retired_q;
    assign perf_flushes_OUT = perf_flushes_q;
`else
    // Performance counters are not built in this configuration.
`endif

    assign flush_OUT          = flush_q;
    assign copy_retrat_OUT    = flush_q;
    assign redirect_valid_OUT = redirect_valid_q;
    assign redirect_pc_OUT    = redirect_pc_q;
    assign commit_cnt_OUT     = commit_cnt_q;

endmodule
`default_nettype wire
